// File: rtl/led_arb_pkg.sv
// Shared types for the LED bank arbiter: FSM state encoding and LED bank widths.
// Imported by led_arbiter and rr_pick.
package led_arb_pkg;

  localparam int LEDR_W = 10;
  localparam int LEDG_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req after last_owner, with wrap.
// Ports: req (requests), last_owner (index) -> winner (one-hot), valid (any winner).
module rr_pick
  import led_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic [NREQ-1:0]         winner,
  output logic                    valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    // Offset 1 first, offset NREQ last: the previous owner has lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      if (!valid && req[(int'(last_owner) + k) % NREQ]) begin
        winner[(int'(last_owner) + k) % NREQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner arbitration of one red/green LED bank among NREQ requesters.
// Ports: CLOCK_50, RST_N (async low), req, ledr_in, ledg_in -> grant, LEDR, LEDG, busy.
// Define LED_ARB_TIMEOUT_EN to revoke a contested owner after MAX_HOLD cycles.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MIN_HOLD = 5_000_000,
  parameter int MAX_HOLD = 250_000_000
) (
  input  logic                     CLOCK_50,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LEDR_W-1:0]   ledr_in,
  input  logic [NREQ*LEDG_W-1:0]   ledg_in,
  output logic [NREQ-1:0]          grant,
  output logic [LEDR_W-1:0]        LEDR,
  output logic [LEDG_W-1:0]        LEDG,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] MIN_M1 = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] MAX_M1 = CW'(MAX_HOLD - 1);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_owner;
  logic [CW-1:0]   hold_cnt;

  logic [NREQ-1:0] winner;
  logic            win_valid;
  logic [IW-1:0]   win_idx;

  logic [LEDR_W-1:0] own_r;
  logic [LEDG_W-1:0] own_g;
  logic [LEDR_W-1:0] win_r;
  logic [LEDG_W-1:0] win_g;

  logic rel_ok;
  logic timeout;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = IW'(i);
    end
  end

  assign own_r = ledr_in[int'(owner)*LEDR_W +: LEDR_W];
  assign own_g = ledg_in[int'(owner)*LEDG_W +: LEDG_W];
  assign win_r = ledr_in[int'(win_idx)*LEDR_W +: LEDR_W];
  assign win_g = ledg_in[int'(win_idx)*LEDG_W +: LEDG_W];

  // An early drop is held off until the minimum grant length is met.
  assign rel_ok = !req[owner] && (hold_cnt >= MIN_M1);

`ifdef LED_ARB_TIMEOUT_EN
  // grant is the owner's one-hot while in OWN, so this masks the owner out.
  logic others;
  assign others  = |(req & ~grant);
  assign timeout = (hold_cnt == MAX_M1) && others;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      grant      <= '0;
      LEDR       <= '0;
      LEDG       <= '0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
    end else begin
      unique case (state)
        IDLE, GAP: begin
          if (win_valid) begin
            state    <= OWN;
            grant    <= winner;
            owner    <= win_idx;
            hold_cnt <= '0;
            LEDR     <= win_r;
            LEDG     <= win_g;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
            grant <= '0;
            LEDR  <= '0;
            LEDG  <= '0;
            busy  <= 1'b0;
          end
        end
        OWN: begin
          if (rel_ok || timeout) begin
            state      <= GAP;
            grant      <= '0;
            LEDR       <= '0;
            LEDG       <= '0;
            busy       <= 1'b0;
            last_owner <= owner;
          end else begin
            LEDR <= own_r;
            LEDG <= own_g;
            if (hold_cnt != MAX_M1) hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter: directed scenarios plus random traffic
// compared every cycle against an ownership-level reference model.
module tb_led_arbiter;

  localparam int NREQ     = 4;
  localparam int MIN_HOLD = 4;
  localparam int MAX_HOLD = 16;
`ifdef LED_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic            CLOCK_50 = 1'b0;
  logic            RST_N;
  logic [3:0]      req;
  logic [39:0]     ledr_in;
  logic [31:0]     ledg_in;
  logic [3:0]      grant;
  logic [9:0]      LEDR;
  logic [7:0]      LEDG;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  int         m_own;
  int         m_age;
  int         m_last;
  logic [3:0] m_grant;
  logic [9:0] m_ledr;
  logic [7:0] m_ledg;
  logic       m_busy;

  led_arbiter #(
    .NREQ(NREQ), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .req      (req),
    .ledr_in  (ledr_in),
    .ledg_in  (ledg_in),
    .grant    (grant),
    .LEDR     (LEDR),
    .LEDG     (LEDG),
    .busy     (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_age  = 0;
    m_last = NREQ - 1;
  endtask

  // Ownership view: m_own = -1 means nobody owns the bank this cycle.
  task automatic model_step();
    logic [3:0] others;
    if (m_own >= 0) begin
      others = req & ~(4'b0001 << m_own);
      if ((!req[m_own] && m_age >= MIN_HOLD - 1) ||
          (TO && m_age == MAX_HOLD - 1 && others != 0)) begin
        m_last = m_own;
        m_own  = -1;
      end else if (m_age < MAX_HOLD - 1) begin
        m_age++;
      end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int c = (m_last + k) % NREQ;
        if (m_own < 0 && req[c]) begin
          m_own = c;
          m_age = 0;
        end
      end
    end
    m_grant = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    m_ledr  = (m_own >= 0) ? ledr_in[m_own*10 +: 10] : 10'h0;
    m_ledg  = (m_own >= 0) ? ledg_in[m_own*8 +: 8] : 8'h0;
    m_busy  = (m_own >= 0);
  endtask

  task automatic drive_req(input logic [3:0] r);
    @(negedge CLOCK_50);
    req     = r;
    ledr_in = 40'({$urandom(), $urandom()});
    ledg_in = 32'($urandom());
  endtask

  task automatic step_check();
    model_step();
    @(posedge CLOCK_50);
    #1;
    check("grant", grant, m_grant);
    check("ledr", LEDR, m_ledr);
    check("ledg", LEDG, m_ledg);
    check("busy", busy, m_busy);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    req   = '0;
    RST_N = 1'b0;
    #2;
    check("rst_grant", grant, 4'h0);
    check("rst_ledr", LEDR, 10'h0);
    check("rst_ledg", LEDG, 8'h0);
    check("rst_busy", busy, 1'b0);
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] e;
    RST_N   = 1'b0;
    req     = '0;
    ledr_in = '0;
    ledg_in = '0;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    do_reset();

    // First grant goes to the single requester, LEDs loaded on the same edge.
    drive_req(4'b0010);
    ledr_in[19:10] = 10'h2AA;
    step_check();
    check("first_grant", grant, 4'b0010);
    check("first_ledr", LEDR, 10'h2AA);
    check("first_busy", busy, 1'b1);

    // One-cycle pulse still holds MIN_HOLD cycles, then a single gap.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_req(k == 0 ? 4'b0010 : 4'b0000);
      step_check();
      e = (k < 4) ? 4'b0010 : 4'b0000;
      check("pulse_grant", grant, e);
      if (k == 4) check("gap_ledr", LEDR, 10'h0);
    end

    // All requesting: rotation with timeout, otherwise owner 0 stays.
    do_reset();
    for (int k = 0; k < (TO ? 85 : 100); k++) begin
      drive_req(4'b1111);
      step_check();
      if (TO) e = ((k % 17) == 16) ? 4'b0000 : (4'b0001 << ((k / 17) % 4));
      else    e = 4'b0001;
      check("all_req_grant", grant, e);
    end

    // Owner 2 with req 0101 releases; index 0 is next in wrap order.
    do_reset();
    drive_req(4'b0100);
    step_check();
    check("own2_grant", grant, 4'b0100);
    for (int k = 0; k < 5; k++) begin
      drive_req(4'b0101);
      step_check();
    end
    drive_req(4'b0001);
    step_check();
    check("rel2_gap", grant, 4'b0000);
    drive_req(4'b0001);
    step_check();
    check("after_gap", grant, 4'b0001);

    // Reset in the middle of a grant clears everything at once.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_req(4'b0001);
      step_check();
    end
    check("pre_rst_busy", busy, 1'b1);
    do_reset();
    drive_req(4'b1000);
    step_check();
    check("post_rst_grant", grant, 4'b1000);

    // Random traffic with occasional resets.
    do_reset();
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) r = 4'($urandom());
      drive_req(r);
      step_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter MIN_HOLD, default 5_000_000, meaning minimum grant length in cycles (>=1; 100 ms at 50 MHz).
REQ-003 SHALL have parameter MAX_HOLD, default 250_000_000, meaning grant length after which a contested owner is revoked (>MIN_HOLD).
REQ-004 SHALL have port CLOCK_50  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  in  NREQ  per-requester ownership request, active-high, level.
REQ-007 SHALL have port ledr_in  in  NREQ*10  red-LED pattern per requester, slice i = bits [10i+9:10i].
REQ-008 SHALL have port ledg_in  in  NREQ*8  green-LED pattern per requester, slice i = bits [8i+7:8i].
REQ-009 SHALL have port grant  out  NREQ  one-hot (or zero) current owner, registered.
REQ-010 SHALL have port LEDR  out  10  red LED bank, active-high, registered.
REQ-011 SHALL have port LEDG  out  8  green LED bank, active-high, registered.
REQ-012 SHALL have port busy  out  1  high while any requester owns the banks.

Function
REQ-013 SHALL implement FSM states IDLE, OWN, GAP.
REQ-014 IDLE: on an edge where any req bit is high, SHALL enter OWN, set grant to the winner, clear hold_cnt, and load LEDR/LEDG from the winner's slices on that same edge.
REQ-015 Winner SHALL be the first asserted req at or after index (last_owner+1) mod NREQ, searching upward with wrap; last_owner resets to NREQ-1, so index 0 wins first.
REQ-016 OWN: LEDR/LEDG SHALL reload from the owner's slices every edge (1-cycle latency from ledr_in/ledg_in to pins).
REQ-017 OWN: hold_cnt SHALL increment every cycle and saturate at MAX_HOLD-1; width SHALL be $clog2(MAX_HOLD).
REQ-018 OWN -> GAP when req[owner]==0 and hold_cnt>=MIN_HOLD-1; a request dropped earlier SHALL be ignored until MIN_HOLD is met (owner keeps grant and LEDs).
REQ-019 GAP SHALL last exactly one cycle with grant=0, LEDR=0, LEDG=0 and busy=0; last_owner SHALL be updated; then arbitration proceeds as in IDLE (GAP -> OWN if any req, else GAP -> IDLE).
REQ-020 Former owner still requesting SHALL be eligible in arbitration but SHALL have lowest priority.
REQ-021 IDLE: grant=0, LEDR=0, LEDG=0, busy=0.
REQ-022 busy SHALL equal (state==OWN), registered.
REQ-023 req changes from non-owners during OWN SHALL have no effect except under REQ-028.

Reset
REQ-024 RST_N low SHALL asynchronously force state=IDLE, grant=0, LEDR=0, LEDG=0, busy=0, hold_cnt=0, last_owner=NREQ-1.
REQ-025 Reset asserted mid-grant SHALL discard ownership with no GAP cycle; first arbitration SHALL occur on the first edge after RST_N deasserts.

Configuration
REQ-026 Macro LED_ARB_TIMEOUT_EN SHALL control revocation.
REQ-027 Without LED_ARB_TIMEOUT_EN: owner SHALL keep the grant indefinitely while req[owner]=1; MAX_HOLD SHALL only size hold_cnt.
REQ-028 With LED_ARB_TIMEOUT_EN: OWN -> GAP when hold_cnt==MAX_HOLD-1 and any other req bit is high, regardless of req[owner].

Structure
REQ-029 Package led_arb_pkg SHALL hold the state enum, LEDR_W=10 and LEDG_W=8.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs req, last_owner; outputs one-hot winner and valid), combinational.

Verification (bench: NREQ=4, MIN_HOLD=4, MAX_HOLD=16)
REQ-031 Reset, then req=4'b0010, ledr_in slice1=10'h2AA -> next edge grant=4'b0010, LEDR=10'h2AA, busy=1.
REQ-032 req[1] pulsed for 1 cycle -> grant held exactly 4 cycles, then 1 GAP cycle with LEDR=0, then IDLE.
REQ-033 req=4'b1111 held continuously, timeout build -> grants rotate 0,1,2,3,0 with each grant 16 cycles and one GAP cycle between grants.
REQ-034 Same stimulus without LED_ARB_TIMEOUT_EN -> grant stays 4'b0001 for 100 cycles.
REQ-035 Owner 2 releases while req=4'b0101 -> after GAP, grant=4'b0001 (index 0 precedes 2 in wrap order from 3).
REQ-036 RST_N low in cycle 7 of a grant -> grant, LEDR, LEDG and busy all 0 immediately (before the next edge); after release, req=4'b1000 -> grant=4'b1000.
